// File: rtl/axis_i2s_slave.sv
// I2S slave transceiver: external SCLK/LRCK are oversampled on i_clk; RX and TX move as 2-word AXIS packets.
// Optional define I2S_FRAME_CHECK_EN adds slot-length checking with a sticky o_frame_err.
module axis_i2s_slave #(
  parameter int DATA_BITS = 24,
  parameter int SLOT_BITS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i2s_sclk,
  input  logic        i2s_lrck,
  input  logic        i2s_sdin,
  output logic        i2s_sdout,
  output logic [31:0] axis_m_data,
  output logic        axis_m_vld,
  input  logic        axis_m_rdy,
  output logic        axis_m_last,
  input  logic [31:0] axis_s_data,
  input  logic        axis_s_vld,
  output logic        axis_s_rdy,
  input  logic        axis_s_last,
  output logic        o_overrun,
  output logic        o_underrun,
  output logic        o_frame_err
);

  if (DATA_BITS < 8 || DATA_BITS > 32 || SLOT_BITS < 2 || SLOT_BITS > 64) begin : g_bad_param
    $error("axis_i2s_slave: unsupported DATA_BITS/SLOT_BITS");
  end

  localparam logic [5:0] DB6 = 6'(DATA_BITS);

  typedef enum logic {ST_UNSYNC = 1'b0, ST_RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [2:0]           sclk_sync;
  logic [1:0]           lrck_sync;
  logic [1:0]           sdin_sync;
  logic                 sclk_rise, sclk_fall;
  logic                 lr_smp, sd_smp;
  logic                 lr_q;
  logic                 lr_chg, frame_edge;
  logic [5:0]           bit_cnt_q, bit_cnt_d;
  logic                 cap_en;
  logic [DATA_BITS-1:0] sr_l, sr_r;
  logic                 do_frame;
  logic                 slot_bad;

  logic [DATA_BITS-1:0] hold_l, hold_r;
  logic                 m_vld_q, m_last_q;
  logic                 overrun_q;
  logic [31:0]          m_word;

  logic [DATA_BITS-1:0] buf_l, buf_r;
  logic                 buf_full_q, buf_full_d;
  logic                 s_rdy_q;
  logic                 s_accept;
  logic                 underrun_q;
  logic [DATA_BITS-1:0] tx_l, tx_r;
  logic [DATA_BITS-1:0] tx_word, tx_shift;
  logic                 sdout_q;
  logic                 unused_s_data;

  // sclk_sync[1] is the synchronized level, sclk_sync[2] its history for edge detect
  assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
  assign lr_smp     = lrck_sync[1];
  assign sd_smp     = sdin_sync[1];
  assign lr_chg     = sclk_rise && (lr_smp != lr_q);
  assign frame_edge = lr_chg && lr_q && !lr_smp;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (sclk_rise) begin
      if (lr_chg)                  bit_cnt_d = '0;
      else if (bit_cnt_q != 6'd63) bit_cnt_d = bit_cnt_q + 6'd1;
    end
  end

  // bit 0 of each half is the I2S delay bit; data bits sit at counts 1..DATA_BITS
  assign cap_en = sclk_rise && !lr_chg && (bit_cnt_d != 6'd0) && (bit_cnt_d <= DB6);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= '0;
      lrck_sync <= '0;
      sdin_sync <= '0;
      lr_q      <= 1'b0;
      bit_cnt_q <= '0;
      sr_l      <= '0;
      sr_r      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], i2s_sclk};
      lrck_sync <= {lrck_sync[0], i2s_lrck};
      sdin_sync <= {sdin_sync[0], i2s_sdin};
      bit_cnt_q <= bit_cnt_d;
      if (sclk_rise) lr_q <= lr_smp;
      if (cap_en) begin
        if (lr_smp) sr_r <= {sr_r[DATA_BITS-2:0], sd_smp};
        else        sr_l <= {sr_l[DATA_BITS-2:0], sd_smp};
      end
    end
  end

`ifdef I2S_FRAME_CHECK_EN
  localparam logic [6:0] SLOT7 = 7'(SLOT_BITS);
  logic frame_err_q;

  // rises in the finished half = delay bit + bit_cnt increments
  assign slot_bad = lr_chg && (state_q == ST_RUN) && (({1'b0, bit_cnt_q} + 7'd1) != SLOT7);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      frame_err_q <= 1'b0;
    else if (slot_bad) frame_err_q <= 1'b1;
  end

  assign o_frame_err = frame_err_q;
`else
  assign slot_bad    = 1'b0;
  assign o_frame_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_UNSYNC;
    else          state_q <= state_d;
  end

  // first 1->0 LRCK edge only aligns; later ones close a frame
  always_comb begin
    state_d  = state_q;
    do_frame = 1'b0;
    case (state_q)
      ST_UNSYNC: if (frame_edge) state_d = ST_RUN;
      ST_RUN: begin
        if (slot_bad)        state_d  = ST_UNSYNC;
        else if (frame_edge) do_frame = 1'b1;
      end
      default: state_d = ST_UNSYNC;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_l    <= '0;
      hold_r    <= '0;
      m_vld_q   <= 1'b0;
      m_last_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= do_frame && m_vld_q;
      if (do_frame && !m_vld_q) begin
        hold_l   <= sr_l;
        hold_r   <= sr_r;
        m_vld_q  <= 1'b1;
        m_last_q <= 1'b0;
      end else if (m_vld_q && axis_m_rdy) begin
        if (!m_last_q) begin
          m_last_q <= 1'b1;
        end else begin
          m_vld_q  <= 1'b0;
          m_last_q <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    m_word                = '0;
    m_word[DATA_BITS-1:0] = m_last_q ? hold_r : hold_l;
  end

  assign s_accept      = axis_s_vld && s_rdy_q;
  assign unused_s_data = ^axis_s_data;

  // rdy is only high while the buffer is empty, so accept and frame load never collide
  always_comb begin
    buf_full_d = buf_full_q;
    if (do_frame && buf_full_q)   buf_full_d = 1'b0;
    if (s_accept && axis_s_last)  buf_full_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_l      <= '0;
      buf_r      <= '0;
      buf_full_q <= 1'b0;
      s_rdy_q    <= 1'b0;
      tx_l       <= '0;
      tx_r       <= '0;
      underrun_q <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      s_rdy_q    <= (state_d == ST_RUN) && !buf_full_d;
      underrun_q <= do_frame && !buf_full_q;
      if (s_accept) begin
        if (axis_s_last) buf_r <= axis_s_data[DATA_BITS-1:0];
        else             buf_l <= axis_s_data[DATA_BITS-1:0];
      end
      if (do_frame) begin
        if (buf_full_q) begin
          tx_l <= buf_l;
          tx_r <= buf_r;
        end else begin
          tx_l <= '0;
          tx_r <= '0;
        end
      end
    end
  end

  // shifting left by the bit count puts bit DATA_BITS-1-n at the top; counts past the word give 0
  always_comb begin
    tx_word  = lr_q ? tx_r : tx_l;
    tx_shift = tx_word << bit_cnt_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                sdout_q <= 1'b0;
    else if (state_q != ST_RUN)  sdout_q <= 1'b0;
    else if (sclk_fall)          sdout_q <= tx_shift[DATA_BITS-1];
  end

  assign i2s_sdout   = sdout_q;
  assign axis_m_data = m_word;
  assign axis_m_vld  = m_vld_q;
  assign axis_m_last = m_last_q;
  assign axis_s_rdy  = s_rdy_q;
  assign o_overrun   = overrun_q;
  assign o_underrun  = underrun_q;

endmodule

// File: doc/axis_i2s_slave.md
Name: axis_i2s_slave

Overview:
I2S slave transceiver for boards where an external codec or master owns SCLK/LRCK. SCLK and LRCK are inputs, oversampled and edge-detected in the i_clk domain. SDIN is deserialized into 2-word AXIS packets (left, then right with last). 2-word AXIS packets are serialized onto SDOUT, using the same I2S framing as the team's master-mode transceiver: 24-bit words, MSB one SCLK after the LRCK edge, LRCK=0 means left.

Parameters:
DATA_BITS, 24, sample width per channel (8..32); AXIS word = {(32-DATA_BITS)'b0, sample}
SLOT_BITS, 32, expected SCLK periods per LRCK half (used only with I2S_FRAME_CHECK_EN)

Ports:
i_clk  in  1  system clock; must be ≥ 8x SCLK frequency
i_rst_n  in  1  reset, asynchronous, active-low
i2s_sclk  in  1  external bit clock
i2s_lrck  in  1  external word select; 0 = left, 1 = right
i2s_sdin  in  1  serial data from ADC/master
i2s_sdout  out  1  serial data to DAC/master
axis_m_data  out  32  received sample; left word first
axis_m_vld  out  1  master valid
axis_m_rdy  in  1  master ready
axis_m_last  out  1  high on right word
axis_s_data  in  32  sample to transmit; bits [DATA_BITS-1:0] used
axis_s_vld  in  1  slave valid
axis_s_rdy  out  1  slave ready
axis_s_last  in  1  high on right word
o_overrun  out  1  1-cycle pulse: received frame dropped
o_underrun  out  1  1-cycle pulse: TX frame started with no packet buffered
o_frame_err  out  1  sticky slot-length error (feature only)

Behaviour:
- Reset: async assert clears all state. Outputs go to 0: axis_m_vld, axis_m_last, axis_s_rdy, i2s_sdout, pulses, o_frame_err. axis_m_data reads 0.
- Input sync: 2-FF synchronizer on sclk, lrck and sdin, plus one history register. rise/fall = change in the synced sclk.
- On each rise: sample lrck and sdin.
  - If the sampled lrck differs from the previous sample: bit_cnt <= 0 (delay bit, not captured).
  - Otherwise bit_cnt increments, saturating at 63.
- RX capture: on a rise with bit_cnt (post-update) in 1..DATA_BITS, shift sdin into sr_l (lrck=0) or sr_r (lrck=1), MSB first. Bits beyond DATA_BITS are ignored.
- State machine UNSYNC -> RUN:
  - UNSYNC after reset. The block ignores data until the first lrck 1->0 rise.
  - That event moves to RUN without emitting a packet and without loading TX.
- Frame boundary = lrck 1->0 rise in RUN.
  - RX: if axis_m_vld=0, latch sr_l/sr_r into holding registers, set axis_m_vld=1, axis_m_last=0. If axis_m_vld=1, drop the frame and pulse o_overrun.
  - TX: load tx_l/tx_r from the buffer if buffer_full, then clear buffer_full. Otherwise load zeros and pulse o_underrun.
- AXIS master: on vld&rdy with last=0, set last=1 (right word). On vld&rdy with last=1, clear vld and last. axis_m_data = last ? right : left, zero-extended.
- AXIS slave:
  - axis_s_rdy = RUN & !buffer_full, registered.
  - An accepted word with last=0 writes buf_l. An accepted word with last=1 writes buf_r, sets buffer_full, and drops rdy the next cycle.
  - A lone last=1 word is a complete packet; buf_l keeps its previous value.
  - A boundary coinciding with acceptance of the last word: the load sees buffer_full=0 (underrun). The packet is kept for the next frame.
- TX serialize: on each fall in RUN, let n = bit_cnt from the last rise and ch = lrck from the last rise.
  - If n in 0..DATA_BITS-1: sdout <= tx_ch[DATA_BITS-1-n].
  - Otherwise sdout <= 0.
  - sdout is registered and changes ≤4 i_clk after the physical SCLK fall.
- Reset mid-frame returns to UNSYNC. A partial packet in flight on AXIS M is abandoned (vld=0).

Optional Feature:
I2S_FRAME_CHECK_EN:
- Defined: at every lrck transition in RUN, compare the rise count of the finished half against SLOT_BITS. On mismatch, set o_frame_err (sticky until reset), force UNSYNC, and discard the current RX frame.
- Undefined: no check logic; o_frame_err tied 0.

Test Plan:
- Master model at i_clk/16 SCLK, 64 SCLK/frame, sends L=0xABCDEF, R=0x123456, axis_m_rdy=1 -> two beats 0x00ABCDEF (last=0), 0x00123456 (last=1); no overrun.
- AXIS S sends L=0x800001, R=0x7FFFFE before a frame boundary -> sdout MSB-first, MSB sampled on the 2nd SCLK rise after each LRCK edge; zeros in bits 25..32 of each slot.
- axis_m_rdy=0 for 3 frames -> first frame held; o_overrun pulses exactly twice; held data unchanged.
- No AXIS S input -> sdout all 0; o_underrun pulses once per frame in RUN.
- Reset asserted mid-left-slot, released -> no packet until one full frame after the first lrck 1->0; vld, rdy and sdout are 0 throughout reset.
- I2S_FRAME_CHECK_EN with a 30-SCLK left half -> o_frame_err=1, that frame is not emitted, and the block resyncs on the next valid frame.
